// File: rtl/pipeline_dut_pkg.sv
// Shared constants and types for the pipeline_dut codebase slice.
// The optional data transforms are enabled by defining PIPELINE_DUT_XFORM_EN.
package pipeline_dut_pkg;

    localparam int unsigned NUM_STAGES = 4;
    localparam int unsigned ADD_CONST  = 1;
    localparam logic [31:0] XOR_KEY    = 32'h5A5A5A5A;
    localparam int unsigned ROT_AMT    = 4;

    // Transform applied by a stage to the word it captures.
    typedef enum logic [1:0] {
        XfIdent,
        XfAdd,
        XfXor,
        XfRot
    } xform_e;

    // One stage slot at the default 32-bit data width.
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } stage_t;

endpackage

// File: rtl/pipeline_stage.sv
// One pipeline register slice: valid bit plus data word, with a
// synchronous active-high reset, an advance enable and a fixed transform.
module pipeline_stage
    import pipeline_dut_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter xform_e      XFORM      = XfIdent
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned RotAmt  = ROT_AMT % DATA_WIDTH;
    localparam int unsigned KeyReps = (DATA_WIDTH + 31) / 32;
    localparam logic [KeyReps*32-1:0] KeyWide = {KeyReps{XOR_KEY}};
    // XOR pattern repeated out to the full data width.
    localparam logic [DATA_WIDTH-1:0] Key = KeyWide[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] rotated;
    logic [DATA_WIDTH-1:0] data_next;

    // Select the transformed word this stage will capture.
    always_comb begin
        // A zero rotate makes the right shift clear everything, leaving data_in.
        rotated   = (data_in << RotAmt) | (data_in >> (DATA_WIDTH - RotAmt));
        data_next = data_in;
        unique case (XFORM)
            XfIdent: data_next = data_in;
            XfAdd:   data_next = data_in + DATA_WIDTH'(ADD_CONST);
            XfXor:   data_next = data_in ^ Key;
            XfRot:   data_next = rotated;
        endcase
    end

    // Stage register: bubbles are clocked like any other slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (enable) begin
            valid_out <= valid_in;
            data_out  <= data_next;
        end
    end

endmodule

// File: rtl/pipeline_dut.sv
// Four-stage valid/data pipeline with an output register, busy and a
// drain-complete pulse. Define PIPELINE_DUT_XFORM_EN to enable the
// per-stage transforms; otherwise the pipeline is a pure 4-cycle delay line.
module pipeline_dut
    import pipeline_dut_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic                  busy,
    output logic                  done
);

`ifdef PIPELINE_DUT_XFORM_EN
    localparam xform_e Xf1 = XfAdd;
    localparam xform_e Xf2 = XfXor;
    localparam xform_e Xf3 = XfRot;
`else
    localparam xform_e Xf1 = XfIdent;
    localparam xform_e Xf2 = XfIdent;
    localparam xform_e Xf3 = XfIdent;
`endif

    logic [NUM_STAGES-1:0] s_valid;
    logic [NUM_STAGES-1:0] in_valid;
    logic [DATA_WIDTH-1:0] s_data  [NUM_STAGES];
    logic [DATA_WIDTH-1:0] in_data [NUM_STAGES];
    logic                  done_d;

    // Chain each stage's input to the previous stage (stage 0 to the ports).
    always_comb begin
        in_valid   = {s_valid[NUM_STAGES-2:0], valid_in};
        in_data[0] = data_in;
        for (int k = 1; k < NUM_STAGES; k++) begin
            in_data[k] = s_data[k-1];
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        localparam xform_e StageXf = (k == 1) ? Xf1 :
                                     (k == 2) ? Xf2 :
                                     (k == 3) ? Xf3 : XfIdent;
        pipeline_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .XFORM      (StageXf)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .enable    (enable),
            .valid_in  (in_valid[k]),
            .data_in   (in_data[k]),
            .valid_out (s_valid[k]),
            .data_out  (s_data[k])
        );
    end

    // Drain completes when the last stage emits and every stage loads a bubble;
    // in_valid is exactly the set of valid bits the stages are about to load.
    always_comb begin
        done_d = enable & s_valid[NUM_STAGES-1] & ~(|in_valid);
    end

    // Output register; valid_out and done drop during a stall, data holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= enable & s_valid[NUM_STAGES-1];
            done      <= done_d;
            if (enable) begin
                data_out <= s_data[NUM_STAGES-1];
            end
        end
    end

    assign stage_valid = s_valid;
    assign busy        = enable & ((|s_valid) | valid_out);

endmodule

// File: tb/tb_pipeline_dut.sv
// Self-checking bench for pipeline_dut: directed vector table followed by
// randomized traffic checked against a queue-based item-age model.
module tb_pipeline_dut;
    import pipeline_dut_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        valid_in;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic [3:0]  stage_valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pipeline_dut #(
        .DATA_WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .stage_valid (stage_valid),
        .busy        (busy),
        .done        (done)
    );

`ifdef PIPELINE_DUT_XFORM_EN
    localparam logic [31:0] E_A5   = 32'hFFFFFFCF;
    localparam logic [31:0] E_2222 = 32'h87878797;
    localparam logic [31:0] E_1234 = 32'h86E0C234;
    localparam logic [31:0] E_8765 = 32'hD3F1978D;
    localparam logic [31:0] E_DEAD = 32'h4F7E4AA8;
`else
    localparam logic [31:0] E_A5   = 32'hA5A5A5A5;
    localparam logic [31:0] E_2222 = 32'h22222222;
    localparam logic [31:0] E_1234 = 32'h12345678;
    localparam logic [31:0] E_8765 = 32'h87654321;
    localparam logic [31:0] E_DEAD = 32'hDEADBEEF;
`endif

    // End-to-end result for one item, straight from the transform rules.
    function automatic logic [31:0] xf(input logic [31:0] x);
        logic [31:0] t;
`ifdef PIPELINE_DUT_XFORM_EN
        t = x + 32'd1;
        t = t ^ 32'h5A5A5A5A;
        t = {t[27:0], t[31:28]};
`else
        t = x;
`endif
        return t;
    endfunction

    // Model: in-flight items with their age in enabled edges since capture.
    logic [31:0] m_val[$];
    int          m_age[$];
    stage_t      m_out;
    logic        m_done;

    function automatic logic [3:0] model_sv();
        logic [3:0] sv;
        sv = 4'b0000;
        foreach (m_age[i]) if (m_age[i] < 4) sv[m_age[i]] = 1'b1;
        return sv;
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic vin,
                              input logic [31:0] din);
        logic emerged;
        if (rst) begin
            m_val.delete();
            m_age.delete();
            m_out  = '0;
            m_done = 1'b0;
        end else if (!en) begin
            m_out.valid = 1'b0;
            m_done      = 1'b0;
        end else begin
            emerged = 1'b0;
            foreach (m_age[i]) m_age[i]++;
            if (m_age.size() > 0 && m_age[0] == 4) begin
                m_out.data = xf(m_val[0]);
                void'(m_val.pop_front());
                void'(m_age.pop_front());
                emerged = 1'b1;
            end
            if (vin) begin
                m_val.push_back(din);
                m_age.push_back(0);
            end
            m_out.valid = emerged;
            m_done      = emerged && (m_age.size() == 0);
        end
    endtask

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model, sample after the edge.
    task automatic apply(input logic rst, input logic en, input logic vin,
                         input logic [31:0] din);
        reset    = rst;
        enable   = en;
        valid_in = vin;
        data_in  = din;
        @(posedge clk);
        model_step(rst, en, vin, din);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        vin;
        logic [31:0] din;
        logic [3:0]  sv;
        logic        vo;
        logic [31:0] dout;
        logic        dn;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        m_out    = '0;
        m_done   = 1'b0;

        //              rst   en    vin   din           sv       vo    dout    dn    bsy
        // Reset, including a reset that overrides enable and valid_in.
        tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});
        // Single item walks the stages and emerges with done.
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hA5A5A5A5, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0010, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0100, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b1000, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b1, E_A5,   1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});
        // Reset one cycle after capture discards the item.
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h11111111, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});
        for (int i = 0; i < 4; i++)
            tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,    4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});
        // Stall with one item in S0; valid_in during the stall is ignored.
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h22222222, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        4'b0001, 1'b0, 32'h0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h33333333, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0010, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0100, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b1000, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b1, E_2222, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});
        // Back-to-back burst of three; done only with the last.
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h12345678, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h87654321, 4'b0011, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 4'b0111, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b1110, 1'b0, 32'h0,  1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b1100, 1'b1, E_1234, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b1000, 1'b1, E_8765, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b1, E_DEAD, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 32'h0,  1'b0, 1'b0});

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].vin, tbl[i].din);
            check($sformatf("vec%0d stage_valid", i), 32'(stage_valid), 32'(tbl[i].sv));
            check($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(tbl[i].vo));
            check($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].dn));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
            // data_out is only meaningful for a valid result or right after reset.
            if (tbl[i].vo || tbl[i].rst)
                check($sformatf("vec%0d data_out", i), data_out, tbl[i].dout);
        end

        // Randomized traffic with stalls and occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic        r_rst;
            logic        r_en;
            logic        r_vin;
            logic [31:0] r_din;
            r_rst = ($urandom_range(0, 39) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_vin = 1'($urandom_range(0, 1));
            r_din = $urandom;
            apply(r_rst, r_en, r_vin, r_din);
            check("rnd stage_valid", 32'(stage_valid), 32'(model_sv()));
            check("rnd valid_out", 32'(valid_out), 32'(m_out.valid));
            check("rnd done", 32'(done), 32'(m_done));
            check("rnd busy", 32'(busy),
                  32'(r_en & ((|model_sv()) | m_out.valid)));
            if (m_out.valid || r_rst)
                check("rnd data_out", data_out, m_out.data);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
